uart_rx_os16: RTL and testbench

//  Robust UART receiver, 16x oversampled, for 8-bit LSB-first frames (start, data, stop).

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx_os16.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, oversampling constants and bit vote helper for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    localparam int OS_RATE    = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous byte FIFO, push/full write side, valid/ready read side
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    output logic                     overrun,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;
    logic             wr_en;

    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A simultaneous read frees a slot, so a push at full is still accepted.
    assign wr_en     = push && (!full || pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && !wr_en;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x oversampled 8N1 UART receiver with glitch reject, bit voting and output FIFO
// Define UART_RX_PARITY_EN to expect an even parity bit between data and stop.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_serial,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int OS_DIV = CLK_FREQ / (BAUD * OS_RATE);
    localparam int TICK_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

    logic              rx_meta;
    logic              rx_sync;
    logic [TICK_W-1:0] tick_cnt;
    logic              os_tick;
    rx_state_e         state;
    logic [3:0]        os_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic [1:0]        samp;
    logic              push;
    logic              decide;
    logic              bit_val;
    logic              fifo_full;

    assign os_tick = (tick_cnt == TICK_W'(OS_DIV - 1));
    assign decide  = (os_cnt == 4'(SAMPLE_HI));
    assign bit_val = majority3(samp[0], samp[1], rx_sync);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            tick_cnt <= '0;
        end else begin
            rx_meta  <= rx_serial;
            rx_sync  <= rx_meta;
            tick_cnt <= os_tick ? '0 : tick_cnt + 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic parity_err_q;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RX_IDLE;
            os_cnt    <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            samp      <= '0;
            push      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            push      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (os_tick) begin
                if (state != RX_IDLE) begin
                    os_cnt <= os_cnt + 1'b1;
                end
                if (os_cnt == 4'(SAMPLE_LO)) begin
                    samp[0] <= rx_sync;
                end
                if (os_cnt == 4'(SAMPLE_MID)) begin
                    samp[1] <= rx_sync;
                end
                case (state)
                    RX_IDLE: begin
                        if (!rx_sync) begin
                            state  <= RX_START;
                            os_cnt <= '0;
                        end
                    end
                    RX_START: begin
                        if (decide && bit_val) begin
                            state <= RX_IDLE;
                        end else if (os_cnt == 4'd15) begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end
                    end
                    RX_DATA: begin
                        if (decide) begin
                            shift[bit_idx] <= bit_val;
                        end
                        if (os_cnt == 4'd15) begin
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= RX_PARITY;
`else
                                state <= RX_STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    RX_PARITY: begin
                        if (decide) begin
                            par_bit <= bit_val;
                        end
                        if (os_cnt == 4'd15) begin
                            state <= RX_STOP;
                        end
                    end
`endif
                    // Leave at mid-stop so the next start edge is caught without a gap.
                    RX_STOP: begin
                        if (decide) begin
                            if (!bit_val) begin
                                frame_err <= 1'b1;
                                state     <= RX_BREAK;
                            end else begin
`ifdef UART_RX_PARITY_EN
                                if (par_bit != ^shift) begin
                                    parity_err_q <= 1'b1;
                                end else begin
                                    push <= 1'b1;
                                end
`else
                                push <= 1'b1;
`endif
                                state <= RX_IDLE;
                            end
                        end
                    end
                    RX_BREAK: begin
                        if (rx_sync) begin
                            state <= RX_IDLE;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift),
        .full      (fifo_full),
        .overrun   (overrun),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - scoreboard bench for uart_rx_os16 at 16 clk per bit
module tb_uart_rx_os16;
    import uart_pkg::*;

    localparam int CLK_FREQ   = 16_000_000;
    localparam int BAUD       = 1_000_000;
    localparam int FIFO_DEPTH = 8;
    localparam int BIT_CLKS   = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_serial = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic [3:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int n_checks = 0;
    int n_errors = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    int valid_cycles = 0;
    int f0, o0, p0, v0;
    logic [7:0] exp_q[$];

    uart_rx_os16 #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_serial  (rx_serial),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err)  ferr_cnt++;
            if (overrun)    ovr_cnt++;
            if (parity_err) perr_cnt++;
            if (out_valid)  valid_cycles++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("byte_was_expected", 32'(exp_q.size() != 0), 32'd1);
                end else begin
                    check("rx_byte", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic hold_line(input logic v, input int n);
        rx_serial = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        hold_line(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        hold_line(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            hold_line(d[i], BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        hold_line((^d) ^ par_flip, BIT_CLKS);
`else
        if (par_flip) begin
            hold_line(1'b1, 0);
        end
`endif
        hold_line(stop_bit, BIT_CLKS);
        rx_serial = 1'b1;
    endtask

    task automatic snap();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        p0 = perr_cnt;
        v0 = valid_cycles;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_fifo_count", 32'(fifo_count), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        reset = 1'b0;
        idle(20);

        // single good byte
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(24);
        check("a5_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("a5_frame_err", 32'(ferr_cnt - f0), 32'd0);
        check("a5_overrun", 32'(ovr_cnt - o0), 32'd0);
        check("a5_parity_err", 32'(perr_cnt - p0), 32'd0);
        check("a5_drained", 32'(exp_q.size()), 32'd0);

        // short low glitch
        snap();
        hold_line(1'b0, 3);
        idle(48);
        check("glitch_state_idle", 32'(dut.state), 32'(RX_IDLE));
        check("glitch_no_byte", 32'(valid_cycles - v0), 32'd0);
        check("glitch_frame_err", 32'(ferr_cnt - f0), 32'd0);

        // bad stop bit, then recovery
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(32);
        check("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_fifo_empty", 32'(fifo_count), 32'd0);
        check("ferr_no_byte", 32'(valid_cycles - v0), 32'd0);
        check("ferr_state_idle", 32'(dut.state), 32'(RX_IDLE));
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(24);
        check("after_ferr_drained", 32'(exp_q.size()), 32'd0);

        // fill to full and overrun on the ninth byte
        snap();
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i <= FIFO_DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
        end
        idle(32);
        check("full_count", 32'(fifo_count), 32'd8);
        check("full_overrun", 32'(ovr_cnt - o0), 32'd1);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_frame_err", 32'(ferr_cnt - f0), 32'd0);
        out_ready = 1'b1;
        idle(20);
        check("drain_count", 32'(fifo_count), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        // back-to-back frames
        snap();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(32);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        check("b2b_frame_err", 32'(ferr_cnt - f0), 32'd0);

        // reset during a frame with a byte parked in the FIFO
        out_ready = 1'b0;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 1'b0);
        idle(24);
        check("park_count", 32'(fifo_count), 32'd1);
        hold_line(1'b0, BIT_CLKS);
        hold_line(1'b1, BIT_CLKS);
        hold_line(1'b0, BIT_CLKS);
        reset = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_fifo_count", 32'(fifo_count), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_state", 32'(dut.state), 32'(RX_IDLE));
        exp_q.delete();
        reset = 1'b0;
        out_ready = 1'b1;
        idle(20);
        snap();
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(24);
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);
        check("post_rst_frame_err", 32'(ferr_cnt - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(24);
        check("par_err_pulse", 32'(perr_cnt - p0), 32'd1);
        check("par_err_no_byte", 32'(valid_cycles - v0), 32'd0);
        check("par_err_frame_err", 32'(ferr_cnt - f0), 32'd0);
`else
        check("parity_never_pulses", 32'(perr_cnt), 32'd0);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
